// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: paces the alien formation's march. It counts video frames,
// issues horizontal steps or edge-triggered descents, speeds up as aliens die,
// freezes after a player hit and reports invasion / wave-clear upward.
module alien_march_ctrl #(
    parameter int X0            = 16,
    parameter int Y0            = 32,
    parameter int STEP_X        = 4,
    parameter int DROP_Y        = 8,
    parameter int INVADE_Y      = 400,
    parameter int MIN_PERIOD    = 2,
    parameter int FREEZE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [6:0] alive_count,
    input  logic       hit_left,
    input  logic       hit_right,
    input  logic       player_hit,
    output logic [9:0] x_offset,
    output logic [9:0] y_offset,
    output logic       dir,
    output logic       anim_frame,
    output logic       step_pulse,
    output logic       invaded,
    output logic       cleared
);

    localparam int FZ_W = $clog2(FREEZE_FRAMES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEP,
        ST_FREEZE,
        ST_HALT
    } state_t;

    state_t            state, state_next;
    logic [7:0]        frame_cnt, frame_cnt_next;
    logic [FZ_W-1:0]   freeze_cnt, freeze_cnt_next;
    logic [9:0]        x_next, y_next;
    logic              dir_next, anim_next, pulse_next, invaded_next, cleared_next;
    logic [7:0]        period;
    logic              descend;

    // Step period shrinks as aliens die; 2 + 127 still fits in 8 bits.
    assign period  = 8'(MIN_PERIOD) + {1'b0, alive_count};
    // Only the edge in the direction of travel triggers a descent.
    assign descend = dir ? hit_left : hit_right;

    // Next-state and next-output logic for the march sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_next      = state;
        frame_cnt_next  = frame_cnt;
        freeze_cnt_next = freeze_cnt;
        x_next          = x_offset;
        y_next          = y_offset;
        dir_next        = dir;
        anim_next       = anim_frame;
        invaded_next    = invaded;
        cleared_next    = cleared;

        if (start) begin
            state_next      = ST_WAIT;
            frame_cnt_next  = '0;
            freeze_cnt_next = '0;
            x_next          = 10'(X0);
            y_next          = 10'(Y0);
            dir_next        = 1'b0;
            anim_next       = 1'b0;
            invaded_next    = 1'b0;
            cleared_next    = 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (alive_count == 7'd0) begin
                        cleared_next = 1'b1;
                        state_next   = ST_HALT;
                    end else if (player_hit) begin
                        state_next      = ST_FREEZE;
                        freeze_cnt_next = '0;
                        frame_cnt_next  = '0;
                    end else if (frame_tick) begin
                        if (frame_cnt + 8'd1 >= period) begin
                            frame_cnt_next = '0;
                            state_next     = ST_STEP;
                        end else begin
                            frame_cnt_next = frame_cnt + 8'd1;
                        end
                    end
                end
                ST_STEP: begin
                    anim_next = ~anim_frame;
                    if (descend) begin
                        y_next   = y_offset + 10'(DROP_Y);
                        dir_next = ~dir;
                    end else if (dir) begin
                        x_next = x_offset - 10'(STEP_X);
                    end else begin
                        x_next = x_offset + 10'(STEP_X);
                    end
                    // The step always completes before any hit or clear is honoured.
                    if (y_next >= 10'(INVADE_Y)) begin
                        invaded_next = 1'b1;
                        state_next   = ST_HALT;
                    end else if (alive_count == 7'd0) begin
                        cleared_next = 1'b1;
                        state_next   = ST_HALT;
                    end else if (player_hit) begin
                        state_next      = ST_FREEZE;
                        freeze_cnt_next = '0;
                        frame_cnt_next  = '0;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
                ST_FREEZE: begin
                    if (alive_count == 7'd0) begin
                        cleared_next = 1'b1;
                        state_next   = ST_HALT;
                    end else if (frame_tick) begin
                        if (freeze_cnt + FZ_W'(1) == FZ_W'(FREEZE_FRAMES)) begin
                            state_next      = ST_WAIT;
                            freeze_cnt_next = '0;
                            frame_cnt_next  = '0;
                        end else begin
                            freeze_cnt_next = freeze_cnt + FZ_W'(1);
                        end
                    end
                end
                default: ;  // IDLE and HALT hold everything until start
            endcase
        end

        // Registered so the pulse is high exactly while the FSM sits in STEP.
        pulse_next = (state_next == ST_STEP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state      <= ST_IDLE;
            frame_cnt  <= '0;
            freeze_cnt <= '0;
            x_offset   <= 10'(X0);
            y_offset   <= 10'(Y0);
            dir        <= 1'b0;
            anim_frame <= 1'b0;
            step_pulse <= 1'b0;
            invaded    <= 1'b0;
            cleared    <= 1'b0;
        end else begin
            state      <= state_next;
            frame_cnt  <= frame_cnt_next;
            freeze_cnt <= freeze_cnt_next;
            x_offset   <= x_next;
            y_offset   <= y_next;
            dir        <= dir_next;
            anim_frame <= anim_next;
            step_pulse <= pulse_next;
            invaded    <= invaded_next;
            cleared    <= cleared_next;
        end
    end

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Testbench for alien_march_ctrl: directed test-plan steps followed by a long
// randomized run, every cycle compared against a rule-level game model.
module tb_alien_march_ctrl;

    localparam int X0  = 16;
    localparam int Y0  = 32;
    localparam int SX  = 4;
    localparam int DY  = 8;
    localparam int INV = 48;
    localparam int MINP = 2;
    localparam int FF  = 60;

    // Model phases of the march (the bench's own view of the game).
    localparam int P_IDLE = 0, P_MARCH = 1, P_STEPPING = 2, P_FROZEN = 3, P_OVER = 4;

    logic       clk = 1'b0;
    logic       reset, start, frame_tick, hit_left, hit_right, player_hit;
    logic [6:0] alive_count;
    logic [9:0] x_offset, y_offset;
    logic       dir, anim_frame, step_pulse, invaded, cleared;

    int tests = 0;
    int fails = 0;

    int m_x, m_y, m_dir, m_anim, m_inv, m_clr, m_pulse;
    int phase, ticks_seen, frozen_ticks;

    alien_march_ctrl #(
        .X0(X0), .Y0(Y0), .STEP_X(SX), .DROP_Y(DY), .INVADE_Y(INV),
        .MIN_PERIOD(MINP), .FREEZE_FRAMES(FF)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .alive_count(alive_count), .hit_left(hit_left), .hit_right(hit_right),
        .player_hit(player_hit), .x_offset(x_offset), .y_offset(y_offset),
        .dir(dir), .anim_frame(anim_frame), .step_pulse(step_pulse),
        .invaded(invaded), .cleared(cleared)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the game model by one clock using the inputs present at the edge.
    task automatic model_edge();
        if (reset) begin
            m_x = X0; m_y = Y0; m_dir = 0; m_anim = 0; m_inv = 0; m_clr = 0;
            phase = P_IDLE; ticks_seen = 0; frozen_ticks = 0;
        end else if (start) begin
            m_x = X0; m_y = Y0; m_dir = 0; m_anim = 0; m_inv = 0; m_clr = 0;
            phase = P_MARCH; ticks_seen = 0; frozen_ticks = 0;
        end else begin
            case (phase)
                P_MARCH: begin
                    if (alive_count == 0) begin
                        m_clr = 1; phase = P_OVER;
                    end else if (player_hit) begin
                        phase = P_FROZEN; frozen_ticks = 0; ticks_seen = 0;
                    end else if (frame_tick) begin
                        ticks_seen++;
                        if (ticks_seen >= MINP + int'(alive_count)) begin
                            ticks_seen = 0; phase = P_STEPPING;
                        end
                    end
                end
                P_STEPPING: begin
                    if ((m_dir == 0 && hit_right) || (m_dir == 1 && hit_left)) begin
                        m_y = (m_y + DY) % 1024;
                        m_dir = 1 - m_dir;
                    end else if (m_dir == 1) begin
                        m_x = (m_x + 1024 - SX) % 1024;
                    end else begin
                        m_x = (m_x + SX) % 1024;
                    end
                    m_anim = 1 - m_anim;
                    if (m_y >= INV) begin
                        m_inv = 1; phase = P_OVER;
                    end else if (alive_count == 0) begin
                        m_clr = 1; phase = P_OVER;
                    end else if (player_hit) begin
                        phase = P_FROZEN; frozen_ticks = 0; ticks_seen = 0;
                    end else begin
                        phase = P_MARCH;
                    end
                end
                P_FROZEN: begin
                    if (alive_count == 0) begin
                        m_clr = 1; phase = P_OVER;
                    end else if (frame_tick) begin
                        frozen_ticks++;
                        if (frozen_ticks == FF) begin
                            phase = P_MARCH; frozen_ticks = 0; ticks_seen = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_pulse = (phase == P_STEPPING) ? 1 : 0;
    endtask

    task automatic compare_all();
        chk("x_offset",   32'(x_offset),   32'(m_x));
        chk("y_offset",   32'(y_offset),   32'(m_y));
        chk("dir",        32'(dir),        32'(m_dir));
        chk("anim_frame", 32'(anim_frame), 32'(m_anim));
        chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
        chk("invaded",    32'(invaded),    32'(m_inv));
        chk("cleared",    32'(cleared),    32'(m_clr));
    endtask

    // One clock: edge, model update, then sample outputs 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Issue frame_ticks (one every other cycle) until step_pulse is seen.
    // Returns with the DUT sitting in its step cycle so the caller can set edges.
    task automatic wait_step(input int budget, output int nticks);
        bit found = 0;
        nticks = 0;
        for (int k = 1; k <= budget && !found; k++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
            if (step_pulse === 1'b1) begin
                found  = 1;
                nticks = k;
            end else begin
                cycle();
            end
        end
        chk("wait_step_timeout", 32'(found), 32'd1);
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
            cycle();
        end
    endtask

    initial begin
        int nt;
        int pulses;

        reset = 1'b1; start = 1'b0; frame_tick = 1'b0; hit_left = 1'b0;
        hit_right = 1'b0; player_hit = 1'b0; alive_count = 7'd3;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        chk("reset_x", 32'(x_offset), 32'(X0));
        chk("reset_y", 32'(y_offset), 32'(Y0));

        // First step after the 5th tick with three aliens alive.
        start = 1'b1; cycle(); start = 1'b0;
        wait_step(20, nt);
        chk("first_step_ticks", 32'(nt), 32'd5);
        cycle();
        chk("first_step_x", 32'(x_offset), 32'd20);
        chk("first_step_anim", 32'(anim_frame), 32'd1);
        chk("first_step_dir", 32'(dir), 32'd0);

        // Right edge causes a descent and reversal.
        wait_step(20, nt);
        hit_right = 1'b1; cycle(); hit_right = 1'b0;
        chk("descent_y", 32'(y_offset), 32'd40);
        chk("descent_x", 32'(x_offset), 32'd20);
        chk("descent_dir", 32'(dir), 32'd1);
        wait_step(20, nt);
        cycle();
        chk("left_step_x", 32'(x_offset), 32'd16);
        // Right edge while moving left is ignored.
        wait_step(20, nt);
        hit_right = 1'b1; cycle(); hit_right = 1'b0;
        chk("ignored_edge_x", 32'(x_offset), 32'd12);
        chk("ignored_edge_y", 32'(y_offset), 32'd40);

        // Descent to the invasion line halts the march.
        wait_step(20, nt);
        hit_left = 1'b1; cycle(); hit_left = 1'b0;
        chk("invaded_set", 32'(invaded), 32'd1);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
            if (step_pulse === 1'b1) pulses++;
            cycle();
        end
        chk("halt_no_steps", 32'(pulses), 32'd0);
        start = 1'b1; cycle(); start = 1'b0;
        chk("restart_invaded", 32'(invaded), 32'd0);
        chk("restart_y", 32'(y_offset), 32'(Y0));

        // Speed-up: 40 aliens then 1 alive mid-wait.
        alive_count = 7'd40;
        wait_step(100, nt);
        chk("period_42", 32'(nt), 32'd42);
        cycle();
        idle_ticks(20);
        alive_count = 7'd1;
        wait_step(10, nt);
        chk("transition_step", 32'(nt), 32'd1);
        cycle();
        wait_step(10, nt);
        chk("period_3", 32'(nt), 32'd3);
        cycle();

        // Player hit during WAIT freezes for 60 ticks, then a normal period.
        player_hit = 1'b1; cycle(); player_hit = 1'b0;
        wait_step(100, nt);
        chk("freeze_ticks", 32'(nt), 32'(FF + MINP + 1));
        cycle();

        // start beats a coincident player_hit.
        start = 1'b1; player_hit = 1'b1; cycle(); start = 1'b0; player_hit = 1'b0;
        wait_step(10, nt);
        chk("start_beats_hit", 32'(nt), 32'd3);
        cycle();

        // Wave cleared while waiting.
        alive_count = 7'd0;
        cycle();
        chk("cleared_set", 32'(cleared), 32'd1);
        idle_ticks(5);
        alive_count = 7'd3;
        start = 1'b1; cycle(); start = 1'b0;
        chk("restart_cleared", 32'(cleared), 32'd0);

        // Reset in the middle of a freeze.
        wait_step(10, nt);
        cycle();
        player_hit = 1'b1; cycle(); player_hit = 1'b0;
        idle_ticks(5);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("reset_mid_freeze_x", 32'(x_offset), 32'(X0));
        chk("reset_mid_freeze_anim", 32'(anim_frame), 32'd0);

        // Randomized play against the model.
        for (int c = 0; c < 15000; c++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            hit_right  = ($urandom_range(0, 5) == 0);
            hit_left   = ($urandom_range(0, 5) == 0);
            player_hit = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0)
                alive_count = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 40));
            start = ($urandom_range(0, 399) == 0) ||
                    ((phase == P_OVER || phase == P_IDLE) && $urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 2999) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
